// File: rtl/dense_layer_sequencer.sv
// Dense-layer sequencer: per neuron, loads 10 weights + bias, runs the dot-product unit,
// rescales/saturates the 64-bit result and writes it out. Optional ReLU: DENSE_SEQ_RELU_EN.

module dense_layer_sequencer #(
   parameter int AW        = 12,
   parameter int FRAC_BITS = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   input  logic [7:0]    n_neurons_i,
   input  logic [AW-1:0] w_base_i,
   input  logic [319:0]  act_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          w_rd_o,
   output logic [AW-1:0] w_addr_o,
   input  logic [31:0]   w_data_i,
   output logic [319:0]  dp_a_o,
   output logic [319:0]  dp_b_o,
   output logic [31:0]   dp_c_o,
   output logic          dp_start_o,
   input  logic          dp_busy_i,
   input  logic          dp_valid_i,
   input  logic [63:0]   dp_result_i,
   output logic          out_we_o,
   output logic [7:0]    out_addr_o,
   output logic [31:0]   out_data_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_RES,
      S_WRITE,
      S_FINISH
   } state_t;

   state_t state, state_nx;

   logic [7:0]    n_q;
   logic [7:0]    cnt_q;
   logic [AW-1:0] addr_q;
   logic [3:0]    ld_k;
   logic [319:0]  act_q;
   logic [31:0]   wgt_q [10];
   logic [31:0]   bias_q;
   logic [31:0]   res_q;

   logic signed [63:0] shifted;
   logic [31:0]        sat;

   // Result is in range when bits [63:31] are all copies of the sign.
   always_comb begin
      shifted = $signed(dp_result_i) >>> FRAC_BITS;
      if ((&shifted[63:31]) || (~|shifted[63:31])) begin
         sat = shifted[31:0];
      end else if (shifted[63]) begin
         sat = 32'h8000_0000;
      end else begin
         sat = 32'h7FFF_FFFF;
      end
`ifdef DENSE_SEQ_RELU_EN
      if (sat[31]) begin
         sat = '0;
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Dot-product handshake: a rising dp_start_o launches the unit; the result is taken
   // on dp_valid_i only after dp_busy_i has been seen high, so a valid left high from
   // the previous neuron is never mistaken for the new result.
   always_comb begin
      state_nx   = state;
      busy_o     = (state != S_IDLE);
      done_o     = 1'b0;
      dp_start_o = 1'b0;
      out_we_o   = 1'b0;
      w_rd_o     = 1'b0;
      w_addr_o   = '0;
      out_addr_o = '0;
      out_data_o = '0;
      case (state)
         S_IDLE: begin
            if (start_i) begin
               state_nx = (n_neurons_i == 8'd0) ? S_FINISH : S_LOAD;
            end
         end
         S_LOAD: begin
            // Reads go out while ld_k is 0..10; the extra cycle at 11 catches the bias.
            if (ld_k <= 4'd10) begin
               w_rd_o   = 1'b1;
               w_addr_o = addr_q + AW'(ld_k);
            end
            if (ld_k == 4'd11) begin
               state_nx = S_START;
            end
         end
         S_START: begin
            dp_start_o = 1'b1;
            state_nx   = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (dp_busy_i) begin
               state_nx = S_WAIT_RES;
            end
         end
         S_WAIT_RES: begin
            if (dp_valid_i) begin
               state_nx = S_WRITE;
            end
         end
         S_WRITE: begin
            out_we_o   = 1'b1;
            out_addr_o = cnt_q;
            out_data_o = res_q;
            state_nx   = ((cnt_q + 8'd1) == n_q) ? S_FINISH : S_LOAD;
         end
         S_FINISH: begin
            done_o   = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         n_q    <= '0;
         cnt_q  <= '0;
         addr_q <= '0;
         ld_k   <= '0;
         act_q  <= '0;
         bias_q <= '0;
         res_q  <= '0;
         for (int k = 0; k < 10; k++) begin
            wgt_q[k] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  n_q    <= n_neurons_i;
                  addr_q <= w_base_i;
                  act_q  <= act_i;
                  cnt_q  <= '0;
                  ld_k   <= '0;
               end
            end
            S_LOAD: begin
               ld_k <= ld_k + 4'd1;
               if (ld_k == 4'd11) begin
                  bias_q <= w_data_i;
               end else if (ld_k != 4'd0) begin
                  wgt_q[ld_k - 4'd1] <= w_data_i;
               end
            end
            S_WAIT_RES: begin
               if (dp_valid_i) begin
                  res_q <= sat;
               end
            end
            S_WRITE: begin
               cnt_q  <= cnt_q + 8'd1;
               addr_q <= addr_q + AW'(11);
               ld_k   <= '0;
            end
            default: ;
         endcase
      end
   end

   assign dp_a_o = act_q;
   assign dp_c_o = bias_q;

   always_comb begin
      dp_b_o = '0;
      for (int k = 0; k < 10; k++) begin
         dp_b_o[32*k +: 32] = wgt_q[k];
      end
   end

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Bench for dense_layer_sequencer: memory and dot-product unit models, a reference model
// computing neuron outputs from memory contents, and scoreboards for reads and writes.

module tb_dense_layer_sequencer;

   localparam int AW        = 12;
   localparam int FRAC_BITS = 8;
   localparam longint SAT_MAX = 64'sd2147483647;
   localparam longint SAT_MIN = -64'sd2147483648;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          start_i = 1'b0;
   logic [7:0]    n_neurons_i = '0;
   logic [AW-1:0] w_base_i = '0;
   logic [319:0]  act_i = '0;
   logic          busy_o, done_o, w_rd_o, dp_start_o, out_we_o;
   logic [AW-1:0] w_addr_o;
   logic [31:0]   w_data_i = '0;
   logic [319:0]  dp_a_o, dp_b_o;
   logic [31:0]   dp_c_o;
   logic          dp_busy_i = 1'b0;
   logic          dp_valid_i = 1'b0;
   logic [63:0]   dp_result_i = '0;
   logic [7:0]    out_addr_o;
   logic [31:0]   out_data_o;

   dense_layer_sequencer #(.AW(AW), .FRAC_BITS(FRAC_BITS)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .n_neurons_i(n_neurons_i),
      .w_base_i(w_base_i), .act_i(act_i), .busy_o(busy_o), .done_o(done_o),
      .w_rd_o(w_rd_o), .w_addr_o(w_addr_o), .w_data_i(w_data_i),
      .dp_a_o(dp_a_o), .dp_b_o(dp_b_o), .dp_c_o(dp_c_o), .dp_start_o(dp_start_o),
      .dp_busy_i(dp_busy_i), .dp_valid_i(dp_valid_i), .dp_result_i(dp_result_i),
      .out_we_o(out_we_o), .out_addr_o(out_addr_o), .out_data_o(out_data_o)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk_i = ~clk_i;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // ---------------- scoreboard state ----------------
   int vectors = 0;
   int miscompares = 0;
   logic [31:0]   mem [4096];
   logic [AW-1:0] rd_exp_q [$];
   logic [39:0]   exp_q [$];
   logic [39:0]   fixed_q [$];
   logic [63:0]   ovr_q [$];
   int busy_rises = 0;
   int rises_at_write = 0;
   int start_cnt = 0;
   int write_cnt = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h", name, got, want);
      end
   endtask

   function automatic longint sx(input logic [31:0] v);
      logic signed [31:0] t;
      t = v;
      return t;
   endfunction

   function automatic int rand_val(input int mode);
      if (mode == 2) return int'($urandom);
      return int'($urandom_range(100000)) - 50000;
   endfunction

   // Reference: rescale by FRAC_BITS, clamp to signed 32-bit, optional ReLU.
   function automatic logic [31:0] post(input longint raw);
      longint s;
      logic [31:0] r;
      s = raw >>> FRAC_BITS;
      if (s > SAT_MAX) r = 32'h7FFF_FFFF;
      else if (s < SAT_MIN) r = 32'h8000_0000;
      else r = s[31:0];
`ifdef DENSE_SEQ_RELU_EN
      if (s < 0) r = 32'h0;
`endif
      return r;
   endfunction

   task automatic build_expect(input int n, input logic [AW-1:0] base, input int act_v[10]);
      longint acc;
      logic [AW-1:0] a;
      for (int i = 0; i < n; i++) begin
         acc = 0;
         for (int k = 0; k <= 10; k++) begin
            a = AW'(int'(base) + 11 * i + k);
            rd_exp_q.push_back(a);
            if (k == 10) acc += sx(mem[a]);
            else acc += longint'(act_v[k]) * sx(mem[a]);
         end
         if (i < ovr_q.size()) acc = ovr_q[i];
         if (fixed_q.size() > 0) exp_q.push_back(fixed_q.pop_front());
         else exp_q.push_back({8'(i), post(acc)});
      end
   endtask

   // ---------------- weight memory model (1-cycle read latency) ----------------
   logic          rd_pend = 1'b0;
   logic [AW-1:0] rd_addr_pend = '0;
   always @(negedge clk_i) begin
      w_data_i     = rd_pend ? mem[rd_addr_pend] : 32'hDEAD_BEEF;
      rd_pend      = w_rd_o;
      rd_addr_pend = w_addr_o;
   end

   // ---------------- dot-product unit model ----------------
   int   dp_phase = 0;
   int   dp_cnt = 0;
   logic start_prev = 1'b0;

   function automatic logic [63:0] dot_model();
      longint acc;
      acc = sx(dp_c_o);
      for (int k = 0; k < 10; k++) begin
         acc += sx(dp_a_o[32*k +: 32]) * sx(dp_b_o[32*k +: 32]);
      end
      return acc;
   endfunction

   // valid stays high after a result until the next busy rise
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         dp_busy_i  = 1'b0;
         dp_valid_i = 1'b0;
         dp_phase   = 0;
         start_prev = 1'b0;
      end else begin
         if (dp_start_o && !start_prev) begin
            start_cnt++;
            dp_phase = 1;
            dp_cnt   = $urandom_range(1, 3);
         end else if (dp_phase == 1) begin
            dp_cnt--;
            if (dp_cnt == 0) begin
               dp_busy_i  = 1'b1;
               dp_valid_i = 1'b0;
               busy_rises++;
               dp_phase = 2;
               dp_cnt   = 10;
            end
         end else if (dp_phase == 2) begin
            dp_cnt--;
            if (dp_cnt == 0) begin
               dp_result_i = (ovr_q.size() > 0) ? ovr_q.pop_front() : dot_model();
               dp_busy_i   = 1'b0;
               dp_valid_i  = 1'b1;
               dp_phase    = 0;
            end
         end
         start_prev = dp_start_o;
      end
   end

   // ---------------- monitors ----------------
   always @(negedge clk_i) begin
      if (w_rd_o) begin
         if (rd_exp_q.size() == 0) check("rd_unexpected", 64'(w_addr_o) | 64'h1_0000, 64'h0);
         else check("rd_addr", 64'(w_addr_o), 64'(rd_exp_q.pop_front()));
      end
   end

   always @(negedge clk_i) begin
      if ((int'(out_we_o) + int'(done_o) + int'(dp_start_o)) > 1) check("strobe_overlap", 64'd1, 64'd0);
      if (out_we_o) begin
         write_cnt++;
         if (exp_q.size() == 0) begin
            check("wr_unexpected", 64'd1, 64'd0);
         end else begin
            check("wr_addr_data", {24'b0, out_addr_o, out_data_o}, {24'b0, exp_q.pop_front()});
            check("fresh_busy", 64'(busy_rises > rises_at_write), 64'd1);
            rises_at_write = busy_rises;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_zero(input string tag);
      check({tag, "_busy"}, 64'(busy_o), 0);
      check({tag, "_done"}, 64'(done_o), 0);
      check({tag, "_w_rd"}, 64'(w_rd_o), 0);
      check({tag, "_w_addr"}, 64'(w_addr_o), 0);
      check({tag, "_dp_start"}, 64'(dp_start_o), 0);
      check({tag, "_out_we"}, 64'(out_we_o), 0);
      check({tag, "_out_addr"}, 64'(out_addr_o), 0);
      check({tag, "_out_data"}, 64'(out_data_o), 0);
      check({tag, "_dp_a"}, 64'(|dp_a_o), 0);
      check({tag, "_dp_b"}, 64'(|dp_b_o), 0);
      check({tag, "_dp_c"}, 64'(dp_c_o), 0);
   endtask

   task automatic make_act(input int mode, output int act_v[10], output logic [319:0] packed_act);
      for (int k = 0; k < 10; k++) begin
         act_v[k] = (mode == 1) ? 1 : rand_val(mode);
         packed_act[32*k +: 32] = act_v[k];
      end
   endtask

   task automatic run_layer(input int n, input logic [AW-1:0] base, input int act_mode, input bit hold);
      int act_v[10];
      logic [319:0] packed_act;
      int starts_before, writes_before, done_cnt, busy_cyc, late_busy;
      bit finished;
      make_act(act_mode, act_v, packed_act);
      build_expect(n, base, act_v);
      starts_before = start_cnt;
      writes_before = write_cnt;
      @(negedge clk_i);
      start_i = 1'b1; n_neurons_i = 8'(n); w_base_i = base; act_i = packed_act;
      done_cnt = 0; busy_cyc = 0; finished = 0; late_busy = 0;
      for (int c = 0; c < 60 * n + 100 && !finished; c++) begin
         @(negedge clk_i);
         if (!hold) start_i = 1'b0;
         if (busy_o) busy_cyc++;
         if (done_o) begin
            done_cnt++;
            finished = 1;
            start_i = 1'b0;
         end
      end
      start_i = 1'b0;
      if (!finished) check("layer_timeout", 64'd0, 64'd1);
      repeat (4) begin
         @(negedge clk_i);
         if (busy_o) late_busy++;
         if (done_o) done_cnt++;
      end
      check("done_pulses", 64'(done_cnt), 64'd1);
      check("idle_after_done", 64'(late_busy), 64'd0);
      check("writes_left", 64'(exp_q.size()), 64'd0);
      check("reads_left", 64'(rd_exp_q.size()), 64'd0);
      check("dp_starts", 64'(start_cnt - starts_before), 64'(n));
      check("write_count", 64'(write_cnt - writes_before), 64'(n));
      if (n == 0) check("busy_cycles_n0", 64'(busy_cyc), 64'd1);
      exp_q.delete(); rd_exp_q.delete(); ovr_q.delete(); fixed_q.delete();
   endtask

   task automatic reset_mid_layer();
      int act_v[10];
      logic [319:0] packed_act;
      int writes_before;
      bit seen;
      make_act(0, act_v, packed_act);
      build_expect(2, 12'h500, act_v);
      writes_before = write_cnt;
      @(negedge clk_i);
      start_i = 1'b1; n_neurons_i = 8'd2; w_base_i = 12'h500; act_i = packed_act;
      @(negedge clk_i);
      start_i = 1'b0;
      seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk_i);
         if (write_cnt != writes_before) seen = 1;
      end
      if (!seen) check("rst_first_write_timeout", 64'd0, 64'd1);
      seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk_i);
         if (dp_busy_i) seen = 1;
      end
      if (!seen) check("rst_busy_timeout", 64'd0, 64'd1);
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check_zero("midrst");
      exp_q.delete(); rd_exp_q.delete(); ovr_q.delete(); fixed_q.delete();
      repeat (2) @(negedge clk_i);
      check("midrst_no_write", 64'(write_cnt - writes_before), 64'd1);
      rst_ni = 1'b1;
      run_layer(1, 12'h5A0, 0, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = rand_val(0);
      rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      check_zero("reset");
      rst_ni = 1'b1;

      // single neuron: act all 1, weights 256*(1..10), bias 1280 -> 15360 >>> 8 = 60
      for (int k = 0; k < 10; k++) mem[16 + k] = 32'(256 * (k + 1));
      mem[26] = 32'd1280;
      fixed_q.push_back({8'd0, 32'd60});
      run_layer(1, 12'h010, 1, 0);

      run_layer(3, 12'h100, 0, 0);

      ovr_q.push_back(64'h0000_7FFF_FFFF_FF00);
      ovr_q.push_back(64'hFFFF_FF00_0000_0000);
      fixed_q.push_back({8'd0, 32'h7FFF_FFFF});
`ifdef DENSE_SEQ_RELU_EN
      fixed_q.push_back({8'd1, 32'h0000_0000});
`else
      fixed_q.push_back({8'd1, 32'h8000_0000});
`endif
      run_layer(2, 12'h200, 0, 0);

      run_layer(0, 12'h300, 0, 0);
      run_layer(2, 12'h400, 0, 1);
      reset_mid_layer();
      run_layer(3, 12'hFF0, 0, 0);
      run_layer(2, 12'h600, 2, 0);
      repeat (6) run_layer($urandom_range(1, 6), AW'($urandom), $urandom_range(0, 2), 0);
      run_layer(255, 12'h800, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
